// File: rtl/ysyx_23060136_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060136_pipe_ctrl
//
// Purpose: central stall/flush scheduler for the six-stage pipeline
// (IF, ID, EX1, EX2, MEM, WB). It produces the hold (stall*) and bubble
// (flush*) controls of every segment register, arbitrates the hazard
// sources, tracks halt / MEM-timeout conditions in a small FSM and keeps
// saturating performance counters.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   IFU_inst_valid           IF holds a valid instruction
//   ID_rs1/ID_rs2            ID source register indices
//   ID_use_rs1/ID_use_rs2    ID really reads that source
//   EX1_rd/EX2_rd            destination index in EX1 / EX2
//   EX1/EX2_mem_to_reg       instruction in that stage is a load
//   EX2_branch_taken         EX2 resolved a taken jump/branch
//   MEM_req_valid            MEM has an outstanding bus request
//   MEM_resp_valid           bus response returns this cycle
//   WB_system_halt           halt instruction retiring in WB
//   stallIF..stallMEM        hold PC / segment register feeding that stage
//   flushID..flushWB         load a bubble into register feeding that stage
//   redirect_fire            PC redirect accepted this cycle
//   halted, mem_timeout      sticky status flags
//   stall_cycles             saturating count of cycles with stallIF=1
//   redirect_count           saturating count of accepted redirects
// ---------------------------------------------------------------------------
module ysyx_23060136_pipe_ctrl #(
  parameter int GPR_W       = 5,
  parameter int MEM_TIMEOUT = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IFU_inst_valid,
  input  logic [GPR_W-1:0] ID_rs1,
  input  logic [GPR_W-1:0] ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [GPR_W-1:0] EX1_rd,
  input  logic [GPR_W-1:0] EX2_rd,
  input  logic             EX1_mem_to_reg,
  input  logic             EX2_mem_to_reg,
  input  logic             EX2_branch_taken,
  input  logic             MEM_req_valid,
  input  logic             MEM_resp_valid,
  input  logic             WB_system_halt,
  output logic             stallIF,
  output logic             stallID,
  output logic             stallEX1,
  output logic             stallEX2,
  output logic             stallMEM,
  output logic             flushID,
  output logic             flushEX1,
  output logic             flushEX2,
  output logic             flushWB,
  output logic             redirect_fire,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT, S_ERR} state_e;

  // +1 keeps the counter at least one bit wide for tiny timeouts
  localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                halted_q, halted_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    redir_cnt_q, redir_cnt_d;

  logic                mem_busy;
  logic                frozen;
  logic                load_use;

  assign mem_busy = MEM_req_valid & ~MEM_resp_valid;
  assign frozen   = (state_q == S_HALT) || (state_q == S_ERR);

  // Load-use detection, one lane per ID source operand
  logic [1:0][GPR_W-1:0] src_idx;
  logic [1:0]            src_use;
  logic [1:0]            src_hz;

  assign src_idx[0] = ID_rs1;
  assign src_idx[1] = ID_rs2;
  assign src_use[0] = ID_use_rs1;
  assign src_use[1] = ID_use_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    // x0 is hard-wired zero, so it never creates a dependency
    assign src_hz[gi] = src_use[gi] && (src_idx[gi] != '0) &&
                        ((EX1_mem_to_reg && (EX1_rd == src_idx[gi])) ||
                         (EX2_mem_to_reg && (EX2_rd == src_idx[gi])));
  end

  assign load_use = |src_hz;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (WB_system_halt)  state_d = S_HALT;
        else if (mem_busy)   state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (WB_system_halt)                         state_d = S_HALT;
        else if (!mem_busy)                         state_d = S_RUN;
        else if (wait_q == WAIT_LAST)               state_d = S_ERR;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RUN;
    endcase
  end

  // Pipeline controls, zero latency; a stall always wins over the flush of
  // the same register because each priority level drives only one of them.
  always_comb begin
    stallIF       = 1'b0;
    stallID       = 1'b0;
    stallEX1      = 1'b0;
    stallEX2      = 1'b0;
    stallMEM      = 1'b0;
    flushID       = 1'b0;
    flushEX1      = 1'b0;
    flushEX2      = 1'b0;
    flushWB       = 1'b0;
    redirect_fire = 1'b0;
    if (!rst) begin
      flushID  = 1'b1;
      flushEX1 = 1'b1;
      flushEX2 = 1'b1;
      flushWB  = 1'b1;
    end else if (frozen || mem_busy) begin
      // Freeze the whole front of the pipe; WB gets bubbles so nothing
      // retires twice while MEM holds its instruction.
      stallIF  = 1'b1;
      stallID  = 1'b1;
      stallEX1 = 1'b1;
      stallEX2 = 1'b1;
      stallMEM = 1'b1;
      flushWB  = 1'b1;
    end else if (EX2_branch_taken) begin
      flushID       = 1'b1;
      flushEX1      = 1'b1;
      flushEX2      = 1'b1;
      redirect_fire = 1'b1;
    end else if (load_use) begin
      stallIF  = 1'b1;
      stallID  = 1'b1;
      flushEX1 = 1'b1;
    end else if (!IFU_inst_valid) begin
      flushID = 1'b1;
    end
  end

  always_comb begin
    wait_d      = '0;
    if ((state_q == S_MEM_WAIT) && (state_d == S_MEM_WAIT))
      wait_d = wait_q + WAIT_W'(1);
    halted_d    = halted_q  | (state_d == S_HALT);
    timeout_d   = timeout_q | (state_d == S_ERR);
    stall_cnt_d = stall_cnt_q;
    if (stallIF && !frozen && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    redir_cnt_d = redir_cnt_q;
    if (redirect_fire && !(&redir_cnt_q))
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      wait_q      <= '0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign halted         = halted_q;
  assign mem_timeout    = timeout_q;
  assign stall_cycles   = stall_cnt_q;
  assign redirect_count = redir_cnt_q;

endmodule

// File: tb/tb_ysyx_23060136_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060136_pipe_ctrl
//
// Directed-vector bench with a scoreboard: the driver applies one vector per
// cycle (just after the rising edge) and pushes the hand-computed expected
// response; the monitor pops and compares on every falling edge.
// Small counter width and timeout make saturation and timeout reachable.
// ---------------------------------------------------------------------------
module tb_ysyx_23060136_pipe_ctrl;

  localparam int GPR_W       = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             IFU_inst_valid;
  logic [GPR_W-1:0] ID_rs1, ID_rs2, EX1_rd, EX2_rd;
  logic             ID_use_rs1, ID_use_rs2;
  logic             EX1_mem_to_reg, EX2_mem_to_reg, EX2_branch_taken;
  logic             MEM_req_valid, MEM_resp_valid, WB_system_halt;
  logic             stallIF, stallID, stallEX1, stallEX2, stallMEM;
  logic             flushID, flushEX1, flushEX2, flushWB;
  logic             redirect_fire, halted, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, redirect_count;

  always #5 clk = ~clk;

  ysyx_23060136_pipe_ctrl #(
    .GPR_W(GPR_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .IFU_inst_valid(IFU_inst_valid),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX1_rd(EX1_rd), .EX2_rd(EX2_rd),
    .EX1_mem_to_reg(EX1_mem_to_reg), .EX2_mem_to_reg(EX2_mem_to_reg),
    .EX2_branch_taken(EX2_branch_taken),
    .MEM_req_valid(MEM_req_valid), .MEM_resp_valid(MEM_resp_valid),
    .WB_system_halt(WB_system_halt),
    .stallIF(stallIF), .stallID(stallID), .stallEX1(stallEX1),
    .stallEX2(stallEX2), .stallMEM(stallMEM),
    .flushID(flushID), .flushEX1(flushEX1), .flushEX2(flushEX2),
    .flushWB(flushWB),
    .redirect_fire(redirect_fire), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  // ctrl = {stallIF,stallID,stallEX1,stallEX2,stallMEM,
  //         flushID,flushEX1,flushEX2,flushWB,redirect_fire}
  typedef struct packed {
    logic [95:0]      name;
    logic [9:0]       ctrl;
    logic             h;
    logic             t;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] rc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected counter values as seen in the current cycle
  logic [CNT_W-1:0] sc_m = '0;
  logic [CNT_W-1:0] rc_m = '0;

  task automatic idle_in();
    IFU_inst_valid   = 1'b1;
    ID_rs1           = '0;
    ID_rs2           = '0;
    ID_use_rs1       = 1'b0;
    ID_use_rs2       = 1'b0;
    EX1_rd           = '0;
    EX2_rd           = '0;
    EX1_mem_to_reg   = 1'b0;
    EX2_mem_to_reg   = 1'b0;
    EX2_branch_taken = 1'b0;
    MEM_req_valid    = 1'b0;
    MEM_resp_valid   = 1'b0;
    WB_system_halt   = 1'b0;
  endtask

  // Push the expectation for the vector currently applied, then advance
  // one cycle and account for the counter updates on that edge.
  task automatic cyc(input logic [95:0] name, input logic [4:0] st,
                     input logic [3:0] fl, input logic rf,
                     input logic h, input logic t);
    exp_t e;
    e.name = name;
    e.ctrl = {st, fl, rf};
    e.h    = h;
    e.t    = t;
    e.sc   = sc_m;
    e.rc   = rc_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (st[4] && !(h || t) && (sc_m != '1)) sc_m = sc_m + 1'b1;
    if (rf && (rc_m != '1)) rc_m = rc_m + 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {stallIF, stallID, stallEX1, stallEX2, stallMEM,
               flushID, flushEX1, flushEX2, flushWB, redirect_fire};
        $display("txn %0s ctrl=%b halted=%b timeout=%b sc=%0d rc=%0d",
                 e.name, act, halted, mem_timeout, stall_cycles, redirect_count);
        checks++;
        if (act !== e.ctrl) begin
          failures++;
          $display("FAIL %0s ctrl got=%b want=%b", e.name, act, e.ctrl);
        end
        checks++;
        if ({halted, mem_timeout} !== {e.h, e.t}) begin
          failures++;
          $display("FAIL %0s flags got=%b%b want=%b%b", e.name,
                   halted, mem_timeout, e.h, e.t);
        end
        checks++;
        if ({stall_cycles, redirect_count} !== {e.sc, e.rc}) begin
          failures++;
          $display("FAIL %0s counters got sc=%0d rc=%0d want sc=%0d rc=%0d",
                   e.name, stall_cycles, redirect_count, e.sc, e.rc);
        end
        checks++;
        if ({stallID & flushID, stallEX1 & flushEX1, stallEX2 & flushEX2} !== 3'b000) begin
          failures++;
          $display("FAIL %0s stall_flush_overlap got=%b want=000", e.name,
                   {stallID & flushID, stallEX1 & flushEX1, stallEX2 & flushEX2});
        end
      end
    end
  end

  // Driver
  initial begin
    rst = 1'b0;
    idle_in();
    @(posedge clk);
    #1;
    cyc("reset", 5'b00000, 4'b1111, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("idle", 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);

    IFU_inst_valid = 1'b0;
    cyc("if_bubble", 5'b00000, 4'b1000, 1'b0, 1'b0, 1'b0);

    // load-use, EX1 load feeding rs1
    idle_in(); EX1_mem_to_reg = 1'b1; EX1_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
    cyc("lu_ex1", 5'b11000, 4'b0100, 1'b0, 1'b0, 1'b0);
    ID_rs1 = 5'd0; EX1_rd = 5'd0;
    cyc("lu_x0", 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // load-use, EX2 load feeding rs2; beats the fetch bubble
    idle_in(); EX2_mem_to_reg = 1'b1; EX2_rd = 5'd7; ID_rs2 = 5'd7; ID_use_rs2 = 1'b1;
    IFU_inst_valid = 1'b0;
    cyc("lu_ex2", 5'b11000, 4'b0100, 1'b0, 1'b0, 1'b0);
    ID_use_rs2 = 1'b0; IFU_inst_valid = 1'b1;
    cyc("lu_nouse", 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);
    ID_use_rs2 = 1'b1; ID_rs2 = 5'd6;
    cyc("lu_diff", 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // branch overrides load-use
    idle_in(); EX1_mem_to_reg = 1'b1; EX1_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
    EX2_branch_taken = 1'b1;
    cyc("br_lu", 5'b00000, 4'b1110, 1'b1, 1'b0, 1'b0);

    // MEM wait with a coincident taken branch
    idle_in(); MEM_req_valid = 1'b1; EX2_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mem_wait", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b0);
    MEM_resp_valid = 1'b1;
    cyc("mem_rel", 5'b00000, 4'b1110, 1'b1, 1'b0, 1'b0);

    // second wait, one cycle shy of the timeout: wait counter must have cleared
    idle_in(); MEM_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) cyc("mem_wait2", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b0);
    MEM_req_valid = 1'b0;
    cyc("mem_rel2", 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // counter saturation
    idle_in(); EX1_mem_to_reg = 1'b1; EX1_rd = 5'd3; ID_rs2 = 5'd3; ID_use_rs2 = 1'b1;
    for (int i = 0; i < 14; i++) cyc("lu_sat", 5'b11000, 4'b0100, 1'b0, 1'b0, 1'b0);
    idle_in(); EX2_branch_taken = 1'b1;
    for (int i = 0; i < 16; i++) cyc("br_sat", 5'b00000, 4'b1110, 1'b1, 1'b0, 1'b0);
    idle_in();
    cyc("sat_hold", 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // asynchronous reset while in MEM_WAIT
    MEM_req_valid = 1'b1;
    cyc("mw_pre", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b0);
    cyc("mw_pre", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; sc_m = '0; rc_m = '0;
    cyc("arst", 5'b00000, 4'b1111, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; idle_in();
    cyc("post_rst", 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // timeout: RUN + 4 MEM_WAIT cycles, then ERR
    MEM_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) cyc("tmo_wait", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b0);
    cyc("tmo_err", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b1);
    idle_in(); IFU_inst_valid = 1'b0; EX2_branch_taken = 1'b1; WB_system_halt = 1'b1;
    cyc("err_hold", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b1);
    cyc("err_hold", 5'b11111, 4'b0001, 1'b0, 1'b0, 1'b1);

    // reset, then halt during a load-use stall
    rst = 1'b0; sc_m = '0; rc_m = '0; idle_in();
    cyc("rst2", 5'b00000, 4'b1111, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    EX1_mem_to_reg = 1'b1; EX1_rd = 5'd9; ID_rs1 = 5'd9; ID_use_rs1 = 1'b1;
    WB_system_halt = 1'b1;
    cyc("halt_lu", 5'b11000, 4'b0100, 1'b0, 1'b0, 1'b0);
    idle_in(); EX2_branch_taken = 1'b1;
    cyc("halted", 5'b11111, 4'b0001, 1'b0, 1'b1, 1'b0);
    MEM_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) cyc("halt_hold", 5'b11111, 4'b0001, 1'b0, 1'b1, 1'b0);
    idle_in();
    cyc("halt_idle", 5'b11111, 4'b0001, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060136_pipe_ctrl.md
Name: ysyx_23060136_pipe_ctrl

Overview:
- Central stall/flush scheduler for the six-stage core: IF, ID, EX1, EX2, MEM, WB.
- Drives the hold/bubble controls of every segment register, including the EX1→EX2 segment.
- Resolves four hazard sources in priority order: MEM multi-cycle wait, EX2 branch redirect, load-use, fetch not-ready.
- Tracks halt and MEM-timeout in a small FSM, and keeps saturating performance counters.

Parameters:
GPR_W, 5, register index width
MEM_TIMEOUT, 1024, max consecutive MEM_WAIT cycles before error
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
IFU_inst_valid  in  1  IF has a valid instruction this cycle
ID_rs1 / ID_rs2  in  GPR_W  ID source indices
ID_use_rs1 / ID_use_rs2  in  1  ID actually reads that source
EX1_rd / EX2_rd  in  GPR_W  destination in EX1 / EX2
EX1_mem_to_reg / EX2_mem_to_reg  in  1  instruction in that stage is a load
EX2_branch_taken  in  1  EX2 resolved a taken jump/branch
MEM_req_valid  in  1  MEM has an outstanding bus request
MEM_resp_valid  in  1  bus response returns this cycle
WB_system_halt  in  1  halt instruction retiring in WB
stallIF, stallID, stallEX1, stallEX2, stallMEM  out  1 each  hold PC / segment register feeding that stage
flushID, flushEX1, flushEX2, flushWB  out  1 each  load bubble into register feeding that stage
redirect_fire  out  1  PC redirect accepted this cycle
halted  out  1  sticky halt
mem_timeout  out  1  sticky MEM timeout error
stall_cycles  out  CNT_W  cycles with stallIF=1
redirect_count  out  CNT_W  accepted redirects

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT, ERR. Reset state is RUN.
- Reset values: state=RUN, wait counter=0, halted=0, mem_timeout=0, both counters=0.
- While rst is low: all stall=0, all flush=1, redirect_fire=0.
- All stall/flush outputs are combinational from the current state and inputs (zero latency). Counters and flags update on the clock edge.
- mem_busy = MEM_req_valid & ~MEM_resp_valid.
- RUN → MEM_WAIT when mem_busy. MEM_WAIT → RUN when ~mem_busy.
- Any state except ERR → HALT when WB_system_halt. HALT takes priority over MEM transitions.
- MEM_WAIT → ERR when the wait counter reaches MEM_TIMEOUT-1 and mem_busy is still high.
- HALT and ERR are exited only by reset.
- Wait counter increments each cycle in MEM_WAIT and clears on leaving MEM_WAIT.
- Output priority, highest first:
  1. HALT/ERR: every stall=1, flushWB=1, all other flushes=0.
  2. mem_busy (in RUN or MEM_WAIT): stallIF..stallMEM=1, flushWB=1; redirect and load-use are suppressed.
  3. EX2_branch_taken: flushID=flushEX1=flushEX2=1, no stalls, redirect_fire=1.
  4. Load-use: stallIF=stallID=1, flushEX1=1.
     - Condition: for x in {1,2}, ID_use_rsx and ID_rsx≠0 and ((EX1_mem_to_reg and EX1_rd==ID_rsx) or (EX2_mem_to_reg and EX2_rd==ID_rsx)).
  5. ~IFU_inst_valid: flushID=1.
  6. Otherwise all stall and flush outputs are 0.
- Invariant: no segment sees stall and flush together. A stall always masks the flush for the same register.
- halted=1 from the cycle after HALT is entered. mem_timeout=1 from the cycle after ERR is entered.
- stall_cycles increments when stallIF=1 and state is not HALT/ERR.
- redirect_count increments on redirect_fire.
- Both counters saturate at all-ones.
- Reset asserted mid-MEM_WAIT: state returns to RUN immediately; counters and flags clear.

Test Plan:
- Load-use: EX1 load rd=5, ID_rs1=5, use_rs1=1 → stallIF=stallID=1, flushEX1=1 for one cycle. With ID_rs1=0 instead → no stall.
- Branch over load-use: EX2_branch_taken=1 plus load-use condition → flushID/EX1/EX2=1, stalls=0, redirect_fire=1, redirect_count 0→1.
- MEM wait: MEM_req_valid=1, resp=0 for 3 cycles, then resp=1 → stallIF..stallMEM=1 and flushWB=1 for exactly 3 cycles; a coincident taken branch gives redirect_fire=0 until release; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_busy held → mem_timeout=1 after cycle 4; all stalls stay 1 until reset.
- Halt: WB_system_halt pulse during a load-use stall → halted=1 next cycle; all stalls=1 permanently; counters frozen.
- Async reset mid-MEM_WAIT: drop rst between clock edges → flushes=1, stalls=0 immediately; after release, state=RUN and counters=0.
